// File: rtl/character_controller.sv
// Grid-locked sprite movement controller: turns in place on a tap, walks whole tiles while held,
// and stalls (BUMP) at the map edge. Optional macro CHAR_RUN_EN: Run doubles walk speed per tile.
module character_controller #(
  parameter int TILE_PX     = 16,
  parameter int STEP_PX     = 2,
  parameter int TURN_FRAMES = 2,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int X_MAX       = 624,
  parameter int Y_MAX       = 464
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VS,
  input  logic [7:0] keycode,
  input  logic       Run,
  output logic       Character_Moving,
  output logic [1:0] Direction,
  output logic [9:0] Pos_X,
  output logic [9:0] Pos_Y,
  output logic       Step_Done,
  output logic       Blocked
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_WALK = 2'd2;
  localparam logic [1:0] ST_BUMP = 2'd3;

  localparam int PW = $clog2(TILE_PX + 2 * STEP_PX + 1);
  localparam int TW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

  logic [1:0]    state;
  logic [PW-1:0] pix_cnt;
  logic [TW-1:0] turn_cnt;
  logic          fast;
  logic          entry_fast;

  logic vs_meta, vs_sync, vs_last, frame_tick;

  logic          key_valid;
  logic [1:0]    key_dir;
  logic          key_same;
  logic [10:0]   spd;
  logic [10:0]   x_ext, y_ext, x_mv, y_mv;
  logic [PW-1:0] cnt_mv, bump_mv;

`ifdef CHAR_RUN_EN
  assign entry_fast = Run;
`else
  logic unused_run;
  assign unused_run = Run;
  assign entry_fast = 1'b0;
`endif

  // Synchronizer flops reset high so a VS level held through reset is not seen as an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta    <= 1'b1;
      vs_sync    <= 1'b1;
      vs_last    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= VS;
      vs_sync    <= vs_meta;
      vs_last    <= vs_sync;
      frame_tick <= vs_sync & ~vs_last;
    end
  end

  always_comb begin
    key_valid = 1'b1;
    key_dir   = 2'd0;
    case (keycode)
      8'h1A:   key_dir = 2'd0;
      8'h07:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h04:   key_dir = 2'd3;
      default: key_valid = 1'b0;
    endcase
  end

  assign key_same = key_valid && (key_dir == Direction);

  function automatic logic in_bounds(input logic [1:0] d, input logic [10:0] x, input logic [10:0] y);
    case (d)
      2'd0:    return y >= 11'(TILE_PX);
      2'd1:    return (x + 11'(TILE_PX)) <= 11'(X_MAX);
      2'd2:    return (y + 11'(TILE_PX)) <= 11'(Y_MAX);
      default: return x >= 11'(TILE_PX);
    endcase
  endfunction

  // Entering WALK from IDLE uses the live Run level; inside WALK the latched tile speed applies.
  always_comb begin
    if ((state == ST_IDLE) ? entry_fast : fast) spd = 11'(2 * STEP_PX);
    else                                        spd = 11'(STEP_PX);
    x_ext = {1'b0, Pos_X};
    y_ext = {1'b0, Pos_Y};
    x_mv  = x_ext;
    y_mv  = y_ext;
    case (Direction)
      2'd0:    y_mv = y_ext - spd;
      2'd1:    x_mv = x_ext + spd;
      2'd2:    y_mv = y_ext + spd;
      default: x_mv = x_ext - spd;
    endcase
    cnt_mv  = pix_cnt + PW'(spd);
    bump_mv = pix_cnt + PW'(STEP_PX);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= ST_IDLE;
      pix_cnt          <= '0;
      turn_cnt         <= '0;
      fast             <= 1'b0;
      Direction        <= 2'd0;
      Character_Moving <= 1'b0;
      Pos_X            <= 10'(X_INIT);
      Pos_Y            <= 10'(Y_INIT);
      Step_Done        <= 1'b0;
      Blocked          <= 1'b0;
    end else begin
      Step_Done <= 1'b0;
      if (frame_tick) begin
        case (state)
          ST_IDLE: begin
            if (key_valid && (key_dir != Direction)) begin
              Direction <= key_dir;
              turn_cnt  <= '0;
              state     <= ST_TURN;
            end else if (key_same && in_bounds(Direction, x_ext, y_ext)) begin
              state            <= ST_WALK;
              Character_Moving <= 1'b1;
              fast             <= entry_fast;
              Pos_X            <= x_mv[9:0];
              Pos_Y            <= y_mv[9:0];
              pix_cnt          <= PW'(spd);
            end else if (key_same) begin
              state            <= ST_BUMP;
              Character_Moving <= 1'b1;
              Blocked          <= 1'b1;
              pix_cnt          <= '0;
            end
          end
          ST_TURN: begin
            if (turn_cnt == TW'(TURN_FRAMES - 1)) state <= ST_IDLE;
            else                                  turn_cnt <= turn_cnt + 1'b1;
          end
          ST_WALK: begin
            Pos_X <= x_mv[9:0];
            Pos_Y <= y_mv[9:0];
            if (cnt_mv >= PW'(TILE_PX)) begin
              Step_Done <= 1'b1;
              pix_cnt   <= '0;
              // Tile boundary: the only point where a held key can extend or stop the walk.
              if (key_same && in_bounds(Direction, x_mv, y_mv)) begin
                fast <= entry_fast;
              end else if (key_same) begin
                state   <= ST_BUMP;
                Blocked <= 1'b1;
              end else begin
                state            <= ST_IDLE;
                Character_Moving <= 1'b0;
              end
            end else begin
              pix_cnt <= cnt_mv;
            end
          end
          default: begin
            if (bump_mv >= PW'(TILE_PX)) begin
              state            <= ST_IDLE;
              Character_Moving <= 1'b0;
              Blocked          <= 1'b0;
              pix_cnt          <= '0;
            end else begin
              pix_cnt <= bump_mv;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/character_controller.md
# character_controller

Frame-rate movement controller that drives the `Character_Moving` and `Direction` inputs of the sprite colour mapper, and tracks the player's world position in pixels. It decodes the keyboard keycode, applies grid-locked walking: the character turns in place on a tap and walks whole tiles while a key is held. It also refuses steps that would leave the map. All state advances once per video frame, on the rising edge of `VS`, so the animation FSM downstream sees one update per frame.

## Interface
- `TILE_PX`, 16: tile size in pixels; must be a multiple of `2*STEP_PX`.
- `STEP_PX`, 2: pixels moved per frame while walking.
- `TURN_FRAMES`, 2: frames spent turning in place before a walk may start.
- `X_INIT`, 320; `Y_INIT`, 240: reset position, tile-aligned.
- `X_MAX`, 624; `Y_MAX`, 464: largest legal position, tile-aligned.
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous reset, active-low.
- `VS` in 1: vertical sync, asynchronous to `Clk`.
- `keycode` in 8: HID keycode, where 0x1A=up, 0x07=right, 0x16=down, 0x04=left, and anything else means no key.
- `Run` in 1: run button level (used only with `CHAR_RUN_EN`).
- `Character_Moving` out 1: high while walking or bumping.
- `Direction` out 2: facing, where 0=up, 1=right, 2=down, 3=left.
- `Pos_X`, `Pos_Y` out 10: character world position in pixels.
- `Step_Done` out 1: one-`Clk` pulse when a tile walk completes.
- `Blocked` out 1: high while bumping against the map edge.

## Operation
- `VS` passes through a 2-flop synchronizer and a rising-edge detector, producing a one-`Clk` `frame_tick`. All state and outputs change only on `frame_tick`.
- FSM states are IDLE, TURN, WALK and BUMP. There is a turn counter (0..`TURN_FRAMES`-1) and a pixel counter (0..`TILE_PX`).
- IDLE, no key: remain in IDLE with `Character_Moving`=0.
- IDLE, key direction differs from `Direction`:
  - load `Direction` with the key direction;
  - go to TURN with the turn counter cleared.
- IDLE, key direction equals `Direction`:
  - if the next tile is in bounds, go to WALK;
  - otherwise go to BUMP.
- TURN: count frames. After `TURN_FRAMES` frames, return to IDLE, which re-evaluates the key on the next tick.
  - Releasing the key during TURN has no effect; the turn runs to completion.
  - A different key during TURN is ignored until TURN ends.
- WALK: `Character_Moving`=1. Each tick, `Pos` moves `STEP_PX` in `Direction` (up/left decrement, down/right increment) and the pixel counter adds `STEP_PX`.
  - On the tick where the counter reaches `TILE_PX`, pulse `Step_Done`.
  - Then: same key still held and next tile in bounds → stay in WALK with the counter cleared. Same key held and out of bounds → BUMP. Otherwise → IDLE.
  - WALK cannot be interrupted; keycode changes are ignored until the tile boundary.
- Bounds: a step is out of bounds in these cases:
  - up or left with the coordinate < `TILE_PX`;
  - right with `Pos_X` + `TILE_PX` > `X_MAX`;
  - down with `Pos_Y` + `TILE_PX` > `Y_MAX`.
  - Compute with 11-bit intermediates, so no wrap-around is possible.
- BUMP: `Character_Moving`=1 and `Blocked`=1, with `Pos` unchanged. Lasts `TILE_PX/STEP_PX` frames, then goes to IDLE. `Step_Done` does not pulse.
- `Pos` is always tile-aligned in IDLE, TURN and BUMP.

## Timing
- All outputs are registered.
- A `VS` rising edge reaches `frame_tick` 3 `Clk` cycles later. Outputs update on the following `Clk` edge.
- One walked tile = `TILE_PX/STEP_PX` frames (8 at defaults). The first pixel moves on the tick that enters WALK from IDLE.
- `keycode` is sampled only on `frame_tick`.
- Reset (asynchronous, any state, including mid-walk) sets:
  - state IDLE, counters 0;
  - `Direction`=0, `Character_Moving`=0;
  - `Pos_X`=`X_INIT`, `Pos_Y`=`Y_INIT`;
  - `Step_Done`=0, `Blocked`=0.
- A `VS` edge that arrives while `Reset_n` is low is not counted.

## Configuration
- `CHAR_RUN_EN` defined: when `Run`=1 on the tick that enters WALK, that tile walks at `2*STEP_PX` per frame (4 frames at defaults). The speed is latched for the whole tile, and BUMP duration is unchanged.
- `CHAR_RUN_EN` undefined: `Run` is ignored and the speed is always `STEP_PX`.

## Test plan
- Reset, key 0x16 held for 20 frames: TURN to `Direction`=2 for 2 frames, then WALK. `Pos_Y` goes 240→256 over 8 frames, `Step_Done` pulses once per tile, and there is continuous WALK with no IDLE frame between tiles.
- Facing up, 1-frame tap of 0x07: `Direction`=1, `Character_Moving` stays 0 throughout, `Pos` unchanged.
- Set `Pos_X`=0 via `X_INIT`=0, facing left, hold 0x04: BUMP with `Blocked`=1 and `Character_Moving`=1 for 8 frames, `Pos_X` stays 0, and there is no `Step_Done`.
- Mid-WALK (4 frames in), switch key to 0x1A: the walk finishes at +16 px, then 2 TURN frames to `Direction`=0, then walk up.
- Assert `Reset_n`=0 mid-WALK: outputs return to reset values immediately, without waiting for a `Clk` edge.
- `CHAR_RUN_EN` build, hold 0x07 with `Run`=1 while facing right: `Pos_X` 320→336 in 4 frames in 4-px steps. In a build without `CHAR_RUN_EN` the same stimulus takes 8 frames.
